// File: rtl/cgra_cfg_pkg.sv
// Shared types, CRC constants and counter-width helpers for the CGRA
// configuration loader.
package cgra_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VERIFY,
    ST_DONE
  } cfg_state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // One serial CRC-16-CCITT step, MSB-first register.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/cfg_crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator with synchronous clear to the init value.
module cfg_crc16_serial
  import cgra_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] crc_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_reg <= CRC_INIT;
    end else if (clr) begin
      crc_reg <= CRC_INIT;
    end else if (en) begin
      crc_reg <= crc16_step(crc_reg, bit_in);
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/cgra_cfg_loader.sv
// Serialises one config word per tile LSB-first into the tile daisy chain and
// optionally recirculates the chain once to compare a CRC of returned bits.
module cgra_cfg_loader
  import cgra_cfg_pkg::*;
#(
  parameter int N_TILES  = 4,
  parameter int CFG_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                verify,
  input  logic                abort,
  input  logic                cfg_valid,
  input  logic [CFG_BITS-1:0] cfg_data,
  output logic                cfg_ready,
  output logic                program_mode,
  output logic                chain_tdo,
  input  logic                chain_tdi,
  output logic                busy,
  output logic                done,
  output logic                verify_err,
  output logic                aborted
);

  localparam int L      = N_TILES * CFG_BITS;
  localparam int BIT_W  = cnt_width(CFG_BITS);
  localparam int WORD_W = cnt_width(N_TILES + 1);
  localparam int VCNT_W = cnt_width(L + 1);

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(CFG_BITS - 1);
  localparam logic [WORD_W-1:0] WORD_MAX  = WORD_W'(N_TILES);
  localparam logic [VCNT_W-1:0] VCNT_LAST = VCNT_W'(L - 1);

  cfg_state_t          state_reg, state_next;
  logic                verify_mode_reg, verify_mode_next;
  logic [CFG_BITS-1:0] shreg_reg, shreg_next;
  logic                sh_valid_reg, sh_valid_next;
  logic [CFG_BITS-1:0] buf_reg, buf_next;
  logic                buf_valid_reg, buf_valid_next;
  logic [BIT_W-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [WORD_W-1:0]   word_cnt_reg, word_cnt_next;
  logic [VCNT_W-1:0]   vcnt_reg, vcnt_next;
  logic                cfg_ready_reg, cfg_ready_next;
  logic                pm_reg, pm_next;
  logic                tdo_reg, tdo_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic                verify_err_reg, verify_err_next;
  logic                aborted_reg, aborted_next;

  logic        crc_clr, tx_en, tx_bit, rx_en;
  logic        accept, shift_last;
  logic [15:0] tx_crc, rx_crc;

  cfg_crc16_serial u_tx_crc (
    .clk    (clk),
    .rst    (rst),
    .clr    (crc_clr),
    .en     (tx_en),
    .bit_in (tx_bit),
    .crc    (tx_crc)
  );

  cfg_crc16_serial u_rx_crc (
    .clk    (clk),
    .rst    (rst),
    .clr    (crc_clr),
    .en     (rx_en),
    .bit_in (chain_tdi),
    .crc    (rx_crc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= ST_IDLE;
      verify_mode_reg <= 1'b0;
      shreg_reg       <= '0;
      sh_valid_reg    <= 1'b0;
      buf_reg         <= '0;
      buf_valid_reg   <= 1'b0;
      bit_cnt_reg     <= '0;
      word_cnt_reg    <= '0;
      vcnt_reg        <= '0;
      cfg_ready_reg   <= 1'b0;
      pm_reg          <= 1'b0;
      tdo_reg         <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      verify_err_reg  <= 1'b0;
      aborted_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      verify_mode_reg <= verify_mode_next;
      shreg_reg       <= shreg_next;
      sh_valid_reg    <= sh_valid_next;
      buf_reg         <= buf_next;
      buf_valid_reg   <= buf_valid_next;
      bit_cnt_reg     <= bit_cnt_next;
      word_cnt_reg    <= word_cnt_next;
      vcnt_reg        <= vcnt_next;
      cfg_ready_reg   <= cfg_ready_next;
      pm_reg          <= pm_next;
      tdo_reg         <= tdo_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      verify_err_reg  <= verify_err_next;
      aborted_reg     <= aborted_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    verify_mode_next = verify_mode_reg;
    shreg_next       = shreg_reg;
    sh_valid_next    = sh_valid_reg;
    buf_next         = buf_reg;
    buf_valid_next   = buf_valid_reg;
    bit_cnt_next     = bit_cnt_reg;
    word_cnt_next    = word_cnt_reg;
    vcnt_next        = vcnt_reg;
    verify_err_next  = verify_err_reg;
    aborted_next     = aborted_reg;
    crc_clr          = 1'b0;
    tx_en            = 1'b0;
    tx_bit           = shreg_reg[0];
    rx_en            = 1'b0;
    accept           = 1'b0;
    shift_last       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next       = ST_LOAD;
          verify_mode_next = verify;
          verify_err_next  = 1'b0;
          aborted_next     = 1'b0;
          sh_valid_next    = 1'b0;
          buf_valid_next   = 1'b0;
          bit_cnt_next     = '0;
          word_cnt_next    = '0;
          vcnt_next        = '0;
          crc_clr          = 1'b1;
        end
      end

      ST_LOAD: begin
        if (abort) begin
          state_next     = ST_IDLE;
          aborted_next   = 1'b1;
          sh_valid_next  = 1'b0;
          buf_valid_next = 1'b0;
        end else begin
          accept     = cfg_valid && cfg_ready_reg;
          shift_last = sh_valid_reg && (bit_cnt_reg == BIT_LAST);
          if (sh_valid_reg) begin
            tx_en        = 1'b1;
            shreg_next   = shreg_reg >> 1;
            bit_cnt_next = shift_last ? '0 : bit_cnt_reg + 1'b1;
          end
          // Refill from the prefetch buffer on the last bit so words abut.
          if (shift_last) begin
            if (buf_valid_reg) begin
              shreg_next     = buf_reg;
              buf_valid_next = 1'b0;
            end else begin
              sh_valid_next = 1'b0;
            end
          end
          if (accept) begin
            word_cnt_next = word_cnt_reg + 1'b1;
            if (!sh_valid_reg || (shift_last && !buf_valid_reg)) begin
              shreg_next    = cfg_data;
              sh_valid_next = 1'b1;
              bit_cnt_next  = '0;
            end else begin
              buf_next       = cfg_data;
              buf_valid_next = 1'b1;
            end
          end
          if (shift_last && !buf_valid_reg && (word_cnt_reg == WORD_MAX)) begin
            state_next = verify_mode_reg ? ST_VERIFY : ST_DONE;
            vcnt_next  = '0;
          end
        end
      end

      ST_VERIFY: begin
        if (abort) begin
          state_next   = ST_IDLE;
          aborted_next = 1'b1;
        end else begin
          rx_en     = 1'b1;
          vcnt_next = vcnt_reg + 1'b1;
          if (vcnt_reg == VCNT_LAST) begin
            state_next      = ST_DONE;
            // Include the bit being sampled now so the flag is valid with done.
            verify_err_next = (crc16_step(rx_crc, chain_tdi) != tx_crc);
          end
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    busy_next      = (state_next != ST_IDLE);
    done_next      = (state_next == ST_DONE);
    pm_next        = ((state_next == ST_LOAD) && sh_valid_next) || (state_next == ST_VERIFY);
    tdo_next       = (state_next == ST_LOAD) && sh_valid_next && shreg_next[0];
    cfg_ready_next = (state_next == ST_LOAD) && !buf_valid_next && (word_cnt_next < WORD_MAX);
  end

  assign cfg_ready    = cfg_ready_reg;
  assign program_mode = pm_reg;
  assign chain_tdo    = (state_reg == ST_VERIFY) ? chain_tdi : tdo_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign verify_err   = verify_err_reg;
  assign aborted      = aborted_reg;

endmodule
